reg_file_sb: RTL and testbench

Parametrised multi-read-port integer register file with an integrated write-back scoreboard, for the decode/issue stage of the RISC-V core. The decoder reserves each instruction's destination register at issue. The write-back stage commits data and clears the reservation. Read ports return operand data together with a per-port busy flag, which the hazard logic uses to stall. Register 0 is hardwired to zero.

---
 rtl/reg_file_pkg.sv | 19 +
 rtl/reg_file_scoreboard.sv | 48 ++++
 rtl/reg_file_sb.sv | 57 +++++
 tb/tb_reg_file_sb.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// reg_file_pkg: shared defaults and sizing/slice helpers for reg_file_sb and its scoreboard.
package reg_file_pkg;
    localparam int XLEN_DEF = 32;
    localparam int NREG_DEF = 32;

    function automatic int aw_f(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int cnt_w_f(input int n);
        return aw_f(n) + 1;
    endfunction

    localparam int CNT_W = cnt_w_f(NREG_DEF);

    function automatic int slice_lo(input int port, input int w);
        return port * w;
    endfunction
endpackage

// File: rtl/reg_file_scoreboard.sv
// reg_file_scoreboard: busy vector, reservation acceptance, flush priority and reserved-register count.
module reg_file_scoreboard import reg_file_pkg::*; #(
    parameter int  NREG = NREG_DEF,
    localparam int AW   = aw_f(NREG),
    localparam int CW   = cnt_w_f(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            rsv_en,
    input  logic [AW-1:0]   rsv_addr,
    input  logic            flush,
    output logic            rsv_ready,
    output logic [NREG-1:0] busy,
    output logic [CW-1:0]   busy_cnt
);
    logic [NREG-1:0] busy_q, busy_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            rsv_acc;

    assign rsv_ready = !busy_q[rsv_addr] || (wr_en && wr_addr == rsv_addr) || rsv_addr == '0;
    assign rsv_acc   = rsv_en && rsv_ready && !flush;

    // Reservation is applied after the write-back clear so it wins on the same register.
    always_comb begin
        busy_d = busy_q;
        if (wr_en) busy_d[wr_addr] = 1'b0;
        if (rsv_acc) busy_d[rsv_addr] = 1'b1;
        busy_d[0] = 1'b0;
        if (flush) busy_d = '0;
        cnt_d = '0;
        for (int i = 0; i < NREG; i++) cnt_d = cnt_d + CW'(busy_d[i]);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
            cnt_q  <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
        end
    end

    assign busy     = busy_q;
    assign busy_cnt = cnt_q;
endmodule

// File: rtl/reg_file_sb.sv
// reg_file_sb: multi-port integer register file with write-back scoreboard.
// Define REGFILE_BYPASS_EN to forward same-cycle write-back data to the read ports.
module reg_file_sb import reg_file_pkg::*; #(
    parameter int  XLEN = XLEN_DEF,
    parameter int  NREG = NREG_DEF,
    parameter int  NRP  = 2,
    localparam int AW   = aw_f(NREG),
    localparam int CW   = cnt_w_f(NREG)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRP*AW-1:0] rd_addr,
    output logic [NRP*XLEN-1:0] rd_data,
    output logic [NRP-1:0]    rd_busy,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              rsv_en,
    input  logic [AW-1:0]     rsv_addr,
    output logic              rsv_ready,
    input  logic              flush,
    output logic [CW-1:0]     busy_cnt
);
    logic [XLEN-1:0] mem_q [NREG];
    logic [NREG-1:0] busy;

    reg_file_scoreboard #(.NREG(NREG)) u_sb (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .flush    (flush),
        .rsv_ready(rsv_ready),
        .busy     (busy),
        .busy_cnt (busy_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) mem_q <= '{default: '0};
        else if (wr_en && wr_addr != '0) mem_q[wr_addr] <= wr_data;
    end

    for (genvar g = 0; g < NRP; g++) begin : g_rd
        logic [AW-1:0] a;
        logic          byp;
        assign a = rd_addr[slice_lo(g, AW) +: AW];
`ifdef REGFILE_BYPASS_EN
        assign byp = wr_en && wr_addr == a && a != '0;
`else
        assign byp = 1'b0;
`endif
        assign rd_data[slice_lo(g, XLEN) +: XLEN] = (a == '0) ? '0 : byp ? wr_data : mem_q[a];
        assign rd_busy[g] = !byp && busy[a];
    end
endmodule

// File: tb/tb_reg_file_sb.sv
// tb_reg_file_sb: table-driven check of reg_file_sb (two read ports); expectations follow REGFILE_BYPASS_EN.
module tb_reg_file_sb;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic        fl;
        logic [4:0]  a0, a1;
        logic [31:0] d0, d1;
        logic [1:0]  b;
        logic        rdy;
        logic [5:0]  cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [4:0]  a0, a1;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic        wr_en, rsv_en, flush, rsv_ready;
    logic [4:0]  wr_addr, rsv_addr;
    logic [31:0] wr_data;
    logic [5:0]  busy_cnt;
    int          n_run = 0;
    int          n_fail = 0;
    vec_t        q[$];

    always #5 clk = ~clk;

    reg_file_sb dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  ({a1, a0}),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .rsv_en   (rsv_en),
        .rsv_addr (rsv_addr),
        .rsv_ready(rsv_ready),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic re, input logic [4:0] ra, input logic fl,
                                input logic [4:0] p0, input logic [4:0] p1,
                                input logic [31:0] d0, input logic [31:0] d1,
                                input logic [1:0] b, input logic rdy, input logic [5:0] cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra; v.fl = fl;
        v.a0 = p0; v.a1 = p1; v.d0 = d0; v.d1 = d1; v.b = b; v.rdy = rdy; v.cnt = cnt;
        return v;
    endfunction

    initial begin
        rst_n = 1'b0; a0 = '0; a1 = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
        // reserve x5, hold two cycles, then write back
        q.push_back(mk(0, 0, 0, 1, 5, 0, 5, 0, 0, 0, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b01, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 0, 0, 2'b01, 1, 1));
        q.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, BYP ? 32'hDEADBEEF : 32'h0, 0, BYP ? 2'b00 : 2'b01, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 5, 0, 32'hDEADBEEF, 0, 2'b00, 1, 0));
        // WAW stall on x7, then release by same-cycle write
        q.push_back(mk(0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 2'b01, 0, 1));
        q.push_back(mk(0, 0, 0, 0, 7, 0, 7, 0, 0, 0, 2'b01, 0, 1));
        q.push_back(mk(1, 7, 32'h77, 1, 7, 0, 7, 0, BYP ? 32'h77 : 32'h0, 0, BYP ? 2'b00 : 2'b01, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 32'h77, 0, 2'b01, 1, 1));
        q.push_back(mk(1, 7, 32'h78, 0, 0, 0, 7, 0, BYP ? 32'h78 : 32'h77, 0, BYP ? 2'b00 : 2'b01, 1, 1));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 7, 0, 32'h78, 0, 2'b00, 1, 0));
        // x0 write and reservation have no effect
        q.push_back(mk(1, 0, 32'h1234, 1, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 1, 0));
        // reserve x1..x3, then flush with reserve x4 and write x9
        q.push_back(mk(0, 0, 0, 1, 1, 0, 1, 2, 0, 0, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 1, 2, 0, 1, 2, 0, 0, 2'b01, 1, 1));
        q.push_back(mk(0, 0, 0, 1, 3, 0, 1, 2, 0, 0, 2'b11, 1, 2));
        q.push_back(mk(1, 9, 32'h55, 1, 4, 1, 3, 9, 0, BYP ? 32'h55 : 32'h0, 2'b01, 1, 3));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 4, 9, 0, 32'h55, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 2'b00, 1, 0));
        // write x3 while port 1 reads it
        q.push_back(mk(1, 3, 32'hA5A5A5A5, 0, 0, 0, 5, 3, 32'hDEADBEEF, BYP ? 32'hA5A5A5A5 : 32'h0, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 0, 0, 5, 3, 32'hDEADBEEF, 32'hA5A5A5A5, 2'b00, 1, 0));
        q.push_back(mk(1, 3, 32'h1, 1, 3, 0, 5, 3, 32'hDEADBEEF, BYP ? 32'h1 : 32'hA5A5A5A5, 2'b00, 1, 0));
        q.push_back(mk(0, 0, 0, 0, 3, 0, 5, 3, 32'hDEADBEEF, 32'h1, 2'b10, 0, 1));

        repeat (2) @(negedge clk);
        #1;
        chk("in_reset rsv_ready", 32'(rsv_ready), 32'h1);
        chk("in_reset busy_cnt", 32'(busy_cnt), 32'h0);
        chk("in_reset rd_busy", 32'(rd_busy), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        for (int r = 0; r < 32; r++) begin
            a0 = 5'(r);
            a1 = 5'(31 - r);
            #1;
            chk($sformatf("reset x%0d data", r), rd_data[31:0] | rd_data[63:32], 32'h0);
            chk($sformatf("reset x%0d busy", r), 32'(rd_busy), 32'h0);
        end
        chk("reset busy_cnt", 32'(busy_cnt), 32'h0);

        @(negedge clk);
        foreach (q[i]) begin
            wr_en = q[i].we; wr_addr = q[i].wa; wr_data = q[i].wd;
            rsv_en = q[i].re; rsv_addr = q[i].ra; flush = q[i].fl;
            a0 = q[i].a0; a1 = q[i].a1;
            #1;
            chk($sformatf("v%0d rd_data0", i), rd_data[31:0], q[i].d0);
            chk($sformatf("v%0d rd_data1", i), rd_data[63:32], q[i].d1);
            chk($sformatf("v%0d rd_busy", i), 32'(rd_busy), 32'(q[i].b));
            chk($sformatf("v%0d rsv_ready", i), 32'(rsv_ready), 32'(q[i].rdy));
            chk($sformatf("v%0d busy_cnt", i), 32'(busy_cnt), 32'(q[i].cnt));
            @(negedge clk);
        end

        // asynchronous reset mid-operation, asserted between clock edges
        wr_en = 1'b0; rsv_en = 1'b0; flush = 1'b0; rsv_addr = '0; a0 = 5; a1 = 3;
        #1;
        chk("pre_arst x5", rd_data[31:0], 32'hDEADBEEF);
        chk("pre_arst cnt", 32'(busy_cnt), 32'h1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst x5", rd_data[31:0], 32'h0);
        chk("arst x3", rd_data[63:32], 32'h0);
        chk("arst busy", 32'(rd_busy), 32'h0);
        chk("arst cnt", 32'(busy_cnt), 32'h0);
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post_arst x5", rd_data[31:0], 32'h0);
        chk("post_arst rdy", 32'(rsv_ready), 32'h1);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
